// File: rtl/ddr_wr_arbiter.sv
// Shares the AW/W/B channels of one DDR AXI4 slave port among NUM_REQ write masters.
// Latency: AW accepted at cycle N is presented downstream (registered) from N+1; W and B are combinational.
// Backpressure: AW held (no ready) while the W-steering FIFO is full or MAX_OUTST AWs lack a B; W/B follow ddr ready.
//
// Ports:
//   clk_core, rst             : clock and synchronous active-high reset
//   req_aw*  / ddr_aw*        : upstream AW per requester (flattened) -> one registered downstream AW
//   req_w*   / ddr_w*         : upstream W per requester -> downstream W, steered by AW grant order
//   req_b*   / ddr_b*         : downstream B routed back to the requester named by ddr_bid's top 2 bits
//   err_bad_bid               : sticky flag, B handshaken with a tag that names no requester
module ddr_wr_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int UID_W       = 14,
    parameter int WFIFO_DEPTH = 8,
    parameter int MAX_OUTST   = 16
) (
    input  logic                       clk_core,
    input  logic                       rst,
    input  logic [NUM_REQ*UID_W-1:0]   req_awid,
    input  logic [NUM_REQ*64-1:0]      req_awaddr,
    input  logic [NUM_REQ*8-1:0]       req_awlen,
    input  logic [NUM_REQ*3-1:0]       req_awsize,
    input  logic [NUM_REQ*2-1:0]       req_awburst,
    input  logic [NUM_REQ-1:0]         req_awvalid,
    output logic [NUM_REQ-1:0]         req_awready,
    input  logic [NUM_REQ*512-1:0]     req_wdata,
    input  logic [NUM_REQ*64-1:0]      req_wstrb,
    input  logic [NUM_REQ-1:0]         req_wlast,
    input  logic [NUM_REQ-1:0]         req_wvalid,
    output logic [NUM_REQ-1:0]         req_wready,
    output logic [UID_W-1:0]           req_bid,
    output logic [1:0]                 req_bresp,
    output logic [NUM_REQ-1:0]         req_bvalid,
    input  logic [NUM_REQ-1:0]         req_bready,
    output logic [UID_W+1:0]           ddr_awid,
    output logic [63:0]                ddr_awaddr,
    output logic [7:0]                 ddr_awlen,
    output logic [2:0]                 ddr_awsize,
    output logic [1:0]                 ddr_awburst,
    output logic                       ddr_awvalid,
    input  logic                       ddr_awready,
    output logic [511:0]               ddr_wdata,
    output logic [63:0]                ddr_wstrb,
    output logic                       ddr_wlast,
    output logic                       ddr_wvalid,
    input  logic                       ddr_wready,
    input  logic [UID_W+1:0]           ddr_bid,
    input  logic [1:0]                 ddr_bresp,
    input  logic                       ddr_bvalid,
    output logic                       ddr_bready,
    output logic                       err_bad_bid
);
    localparam int PTR_W = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam logic [1:0]       LAST_IDX  = 2'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] OUTST_MAX = CNT_W'(MAX_OUTST);
    localparam logic [PTR_W:0]   FIFO_CAP  = (PTR_W + 1)'(WFIFO_DEPTH);

    typedef enum logic {ST_ARB, ST_SEND} state_t;

    state_t             state_q;
    logic [1:0]         rr_q;
    logic [CNT_W-1:0]   outst_cnt_q;
    logic [UID_W+1:0]   awid_q;
    logic [63:0]        awaddr_q;
    logic [7:0]         awlen_q;
    logic [2:0]         awsize_q;
    logic [1:0]         awburst_q;
    logic               awvalid_q;
    logic               err_q;

    logic [1:0]         fifo_mem_q [WFIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]     fifo_cnt_q;
    logic               fifo_full, fifo_empty, w_pop;
    logic [1:0]         head_idx;

    logic               any_hi, any_lo, grant_vld;
    logic [1:0]         hi_idx, lo_idx, grant_idx;
    logic [UID_W-1:0]   sel_awid;
    logic [63:0]        sel_awaddr;
    logic [7:0]         sel_awlen;
    logic [2:0]         sel_awsize;
    logic [1:0]         sel_awburst;

    logic [1:0]         b_tag;
    logic               tag_ok, bready_sel, b_ok_hs;

    assign fifo_full  = (fifo_cnt_q == FIFO_CAP);
    assign fifo_empty = (fifo_cnt_q == '0);
    assign head_idx   = fifo_mem_q[rd_ptr_q];

    // Round-robin: lowest requester at or above rr_q wins; otherwise wrap to the lowest overall.
    // Descending loop so the final assignment is the lowest matching index.
    always_comb begin
        any_hi = 1'b0;
        any_lo = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_awvalid[i]) begin
                any_lo = 1'b1;
                lo_idx = 2'(i);
                if (2'(i) >= rr_q) begin
                    any_hi = 1'b1;
                    hi_idx = 2'(i);
                end
            end
        end
        grant_idx = any_hi ? hi_idx : lo_idx;
        grant_vld = any_lo && (state_q == ST_ARB) && !fifo_full && (outst_cnt_q < OUTST_MAX);
    end

    always_comb begin
        req_awready = '0;
        sel_awid    = '0;
        sel_awaddr  = '0;
        sel_awlen   = '0;
        sel_awsize  = '0;
        sel_awburst = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == 2'(i)) begin
                req_awready[i] = grant_vld;
                sel_awid       = req_awid[i*UID_W +: UID_W];
                sel_awaddr     = req_awaddr[i*64 +: 64];
                sel_awlen      = req_awlen[i*8 +: 8];
                sel_awsize     = req_awsize[i*3 +: 3];
                sel_awburst    = req_awburst[i*2 +: 2];
            end
        end
    end

    // W is steered by the oldest granted index; payload is forced to zero while nothing is granted.
    always_comb begin
        req_wready = '0;
        ddr_wvalid = 1'b0;
        ddr_wdata  = '0;
        ddr_wstrb  = '0;
        ddr_wlast  = 1'b0;
        if (!fifo_empty) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (head_idx == 2'(i)) begin
                    req_wready[i] = ddr_wready;
                    ddr_wvalid    = req_wvalid[i];
                    ddr_wdata     = req_wdata[i*512 +: 512];
                    ddr_wstrb     = req_wstrb[i*64 +: 64];
                    ddr_wlast     = req_wlast[i];
                end
            end
        end
    end
    assign w_pop = ddr_wvalid && ddr_wready && ddr_wlast;

    // B routing: a tag naming no requester is accepted and discarded so the port never stalls on it.
    assign b_tag = ddr_bid[UID_W+1:UID_W];
    always_comb begin
        tag_ok     = 1'b0;
        bready_sel = 1'b0;
        req_bvalid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (b_tag == 2'(i)) begin
                tag_ok        = 1'b1;
                bready_sel    = req_bready[i];
                req_bvalid[i] = ddr_bvalid;
            end
        end
    end
    assign ddr_bready = tag_ok ? bready_sel : 1'b1;
    assign b_ok_hs    = ddr_bvalid && ddr_bready && tag_ok;
    assign req_bid    = ddr_bid[UID_W-1:0];
    assign req_bresp  = ddr_bresp;

    // AW FSM with registered downstream payload.
    always_ff @(posedge clk_core) begin
        if (rst) begin
            state_q   <= ST_ARB;
            rr_q      <= '0;
            awid_q    <= '0;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            awsize_q  <= '0;
            awburst_q <= '0;
            awvalid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_ARB: begin
                    if (grant_vld) begin
                        awid_q    <= {grant_idx, sel_awid};
                        awaddr_q  <= sel_awaddr;
                        awlen_q   <= sel_awlen;
                        awsize_q  <= sel_awsize;
                        awburst_q <= sel_awburst;
                        awvalid_q <= 1'b1;
                        rr_q      <= (grant_idx == LAST_IDX) ? 2'd0 : grant_idx + 2'd1;
                        state_q   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (ddr_awready) begin
                        awvalid_q <= 1'b0;
                        state_q   <= ST_ARB;
                    end
                end
                default: state_q <= ST_ARB;
            endcase
        end
    end

    // Granted-index FIFO, outstanding counter and sticky error.
    always_ff @(posedge clk_core) begin
        if (rst) begin
            for (int i = 0; i < WFIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            outst_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            if (grant_vld) begin
                fifo_mem_q[wr_ptr_q] <= grant_idx;
                wr_ptr_q             <= wr_ptr_q + 1'b1;
            end
            if (w_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (grant_vld && !w_pop)      fifo_cnt_q <= fifo_cnt_q + 1'b1;
            else if (!grant_vld && w_pop) fifo_cnt_q <= fifo_cnt_q - 1'b1;

            if (grant_vld && !b_ok_hs)                              outst_cnt_q <= outst_cnt_q + 1'b1;
            else if (!grant_vld && b_ok_hs && outst_cnt_q != '0)    outst_cnt_q <= outst_cnt_q - 1'b1;

            if (ddr_bvalid && !tag_ok) err_q <= 1'b1;
        end
    end

    assign ddr_awid    = awid_q;
    assign ddr_awaddr  = awaddr_q;
    assign ddr_awlen   = awlen_q;
    assign ddr_awsize  = awsize_q;
    assign ddr_awburst = awburst_q;
    assign ddr_awvalid = awvalid_q;
    assign err_bad_bid = err_q;
endmodule
